prbs_gen_chk: RTL and testbench
===============================

// Module: prbs_gen_chk
// PURPOSE
//  Runtime-selectable PRBS generator and self-synchronising checker, DATA_WIDTH bits per clock.
//  Successor to the fixed single-bit PRBS15 source. Adds PRBS7/9/15/23/31, a parallel output,
//  error injection and a lock/error-count checker for loopback BIST.
//  Control inputs come from the SPI register map config bus; locked_o/err_cnt_o feed status regs.
// PARAMETERS
//  DATA_WIDTH   8   bits generated/checked per clock, 1..32
//  CNT_W        16  error counter width; counter saturates
//  DEF_POLY     2   poly code applied at reset (2 = PRBS15)
//  LOCK_BEATS   4   consecutive error-free VERIFY beats needed to assert lock
//  LOSS_BEATS   4   consecutive errored LOCKED beats that drop lock
// PORTS
//  clk_i        in   1           clock
//  rst_i        in   1           synchronous reset, active high
//  poly_sel_i   in   3           0:PRBS7 1:PRBS9 2:PRBS15 3:PRBS23 4:PRBS31; 5-7 map to PRBS31
//  seed_i       in   31          seed; only low N bits are used
//  load_i       in   1           load seed and poly; restart checker
//  freeze_i     in   1           hold generator state and output
//  err_inj_i    in   1           invert gen_data_o[0] for the current output word
//  gen_data_o   out  DATA_WIDTH  generated word, bit 0 = oldest bit
//  gen_valid_o  out  1           gen_data_o holds a new word
//  chk_data_i   in   DATA_WIDTH  received word, bit 0 = oldest bit
//  chk_valid_i  in   1           chk_data_i qualifier
//  chk_clear_i  in   1           clear err_cnt_o
//  locked_o     out  1           checker is locked
//  err_cnt_o    out  CNT_W       bit errors counted while locked
//  err_o        out  1           one-cycle pulse: the last LOCKED beat had >= 1 mismatch
// BEHAVIOUR
//  Reset state: poly = DEF_POLY, gen state = 1, gen_data_o = 0, gen_valid_o = 0,
//   locked_o = 0, err_cnt_o = 0, err_o = 0, checker FSM = HUNT.
//  LFSR (Fibonacci), taps (N,T): 7,6 / 9,5 / 15,14 / 23,18 / 31,28.
//   One bit step: b = s[N-1]^s[T-1]; s <= {s[N-2:0], b}; output bit = b.
//   One word = DATA_WIDTH steps; the first step's bit goes to gen_data_o[0].
//  Generator, priority load > freeze > run:
//   load_i: poly <= poly_sel_i; s <= seed_i[N-1:0], or 1 if those bits are all zero; gen_valid_o <= 0.
//   freeze_i: s and gen_data_o hold; gen_valid_o <= 0.
//   run: gen_data_o <= next word; s advances DATA_WIDTH steps; gen_valid_o <= 1.
//   The first valid word appears on the first run edge after load. Latency load->valid = 1 clk.
//  err_inj_i: XOR applied to the word being registered that cycle. LFSR state is unaffected.
//   An injected word is not lost while frozen: injection is ignored when gen_valid_o would be 0.
//  Checker FSM, which advances only on chk_valid_i; uses the registered poly:
//   HUNT:   shift received bits into the checker state (last N received bits).
//           Once >= N bits have been captured, go to VERIFY.
//           If the captured state is all-zero, stay in HUNT and restart the fill.
//   VERIFY: predict the word from the checker state, compare with chk_data_i,
//           advance the state using predicted bits.
//           Mismatch -> HUNT. LOCK_BEATS clean beats in a row -> LOCKED, locked_o <= 1.
//   LOCKED: predict and advance as in VERIFY; never resync from data.
//           err_cnt_o += popcount(mismatch), saturating at all-ones. err_o <= (mismatch != 0).
//           LOSS_BEATS errored beats in a row -> HUNT, locked_o <= 0; err_cnt_o is retained.
//   load_i forces HUNT, locked_o <= 0, and clears the fill and beat counters (not err_cnt_o).
//  chk_clear_i wins over a same-cycle increment; errors in that beat are discarded.
//  A rst_i edge mid-word discards all state. No partial-word output is produced.
// STRUCTURE
//  Package prbs_pkg: poly codes, TAP_N/TAP_T lookup functions, MAX_N = 31.
//  Sub-module prbs_step: combinational DATA_WIDTH-step advance that returns {next_state, word}.
//   It is instantiated twice, once for the generator and once for the checker prediction.
// TESTING
//  1 PRBS7, DATA_WIDTH=8, seed 7'h7F, load then run -> first gen_data_o = 8'h40.
//  2 DATA_WIDTH=1, PRBS7 -> output period is 127 bits with 64 ones. PRBS31 seed 0 -> state loads 1.
//  3 Loopback gen->chk, PRBS15, W=8 -> locked_o rises after 2 fill beats + 4 verify beats; err_cnt_o = 0.
//  4 While locked, one err_inj_i pulse -> err_cnt_o = 1, one err_o pulse, locked_o stays 1.
//  5 chk_data_i = 0 constant -> locked_o never rises. Invert chk_data_i for 4 beats -> lock drops, err_cnt_o kept.
//  6 err_cnt_o at all-ones plus one error -> holds. chk_clear_i with a same-cycle error -> 0.
//    load_i with freeze_i in the same cycle -> load wins, gen_valid_o = 0.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker: polynomial codes,
// checker FSM states and tap lookup helpers.
package prbs_pkg;

  localparam int MAX_N = 31;

  typedef enum logic [2:0] {
    POLY_PRBS7  = 3'd0,
    POLY_PRBS9  = 3'd1,
    POLY_PRBS15 = 3'd2,
    POLY_PRBS23 = 3'd3,
    POLY_PRBS31 = 3'd4
  } poly_e;

  typedef enum logic [1:0] {
    CHK_HUNT,
    CHK_VERIFY,
    CHK_LOCKED
  } chk_state_e;

  // Codes 5..7 are folded onto PRBS31 so the stored poly is always a legal enum value.
  function automatic poly_e normPoly(input logic [2:0] code);
    if (code > 3'd4) return POLY_PRBS31;
    return poly_e'(code);
  endfunction

  function automatic logic [5:0] TAP_N(input poly_e p);
    case (p)
      POLY_PRBS7:  return 6'd7;
      POLY_PRBS9:  return 6'd9;
      POLY_PRBS15: return 6'd15;
      POLY_PRBS23: return 6'd23;
      default:     return 6'd31;
    endcase
  endfunction

  function automatic logic [5:0] TAP_T(input poly_e p);
    case (p)
      POLY_PRBS7:  return 6'd6;
      POLY_PRBS9:  return 6'd5;
      POLY_PRBS15: return 6'd14;
      POLY_PRBS23: return 6'd18;
      default:     return 6'd28;
    endcase
  endfunction

  function automatic logic [MAX_N-1:0] polyMask(input poly_e p);
    return (MAX_N'(1) << TAP_N(p)) - MAX_N'(1);
  endfunction

endpackage

// File: rtl/prbs_gen_chk_if.sv
// Control/status bundle between the config register map and the PRBS block.
interface prbs_gen_chk_if import prbs_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 16
);
  logic [2:0]            poly_sel_i;
  logic [MAX_N-1:0]      seed_i;
  logic                  load_i;
  logic                  freeze_i;
  logic                  err_inj_i;
  logic [DATA_WIDTH-1:0] gen_data_o;
  logic                  gen_valid_o;
  logic [DATA_WIDTH-1:0] chk_data_i;
  logic                  chk_valid_i;
  logic                  chk_clear_i;
  logic                  locked_o;
  logic [CNT_W-1:0]      err_cnt_o;
  logic                  err_o;

  modport master (
    output poly_sel_i, seed_i, load_i, freeze_i, err_inj_i,
    output chk_data_i, chk_valid_i, chk_clear_i,
    input  gen_data_o, gen_valid_o, locked_o, err_cnt_o, err_o
  );

  modport slave (
    input  poly_sel_i, seed_i, load_i, freeze_i, err_inj_i,
    input  chk_data_i, chk_valid_i, chk_clear_i,
    output gen_data_o, gen_valid_o, locked_o, err_cnt_o, err_o
  );
endinterface

// File: rtl/prbs_step.sv
// Combinational DATA_WIDTH-step Fibonacci LFSR advance; bit 0 of the word is the first step.
module prbs_step import prbs_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  poly_e                 i_poly,
  input  logic [MAX_N-1:0]      i_state,
  output logic [MAX_N-1:0]      o_state,
  output logic [DATA_WIDTH-1:0] o_word
);

  logic [MAX_N-1:0] w_mask;
  logic [MAX_N-1:0] w_s;
  logic             w_b;

  assign w_mask = polyMask(i_poly);

  // Masking after each shift keeps bits above N at zero so taps see only the active register.
  always_comb begin
    w_s    = i_state;
    w_b    = 1'b0;
    o_word = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      unique case (i_poly)
        POLY_PRBS7:  w_b = w_s[6]  ^ w_s[5];
        POLY_PRBS9:  w_b = w_s[8]  ^ w_s[4];
        POLY_PRBS15: w_b = w_s[14] ^ w_s[13];
        POLY_PRBS23: w_b = w_s[22] ^ w_s[17];
        default:     w_b = w_s[30] ^ w_s[27];
      endcase
      w_s       = {w_s[MAX_N-2:0], w_b} & w_mask;
      o_word[k] = w_b;
    end
    o_state = w_s;
  end

endmodule

// File: rtl/prbs_gen_chk.sv
// Runtime-selectable PRBS7..31 generator plus self-synchronising lock/error-count checker
// for loopback BIST, DATA_WIDTH bits per clock.
module prbs_gen_chk import prbs_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 16,
  parameter int DEF_POLY   = 2,
  parameter int LOCK_BEATS = 4,
  parameter int LOSS_BEATS = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  prbs_gen_chk_if.slave  bus
);

  localparam poly_e      DEF_P      = normPoly(3'(DEF_POLY));
  localparam logic [7:0] LOCK_LAST  = 8'(LOCK_BEATS - 1);
  localparam logic [7:0] LOSS_LAST  = 8'(LOSS_BEATS - 1);
  localparam logic [6:0] WORD_BITS  = 7'(DATA_WIDTH);

  poly_e                 r_poly;
  logic [MAX_N-1:0]      r_genState;
  logic [DATA_WIDTH-1:0] r_genData;
  logic                  r_genValid;

  chk_state_e            r_chkFsm;
  logic [MAX_N-1:0]      r_chkState;
  logic [6:0]            r_fillCnt;
  logic [7:0]            r_beatCnt;
  logic                  r_locked;
  logic [CNT_W-1:0]      r_errCnt;
  logic                  r_err;

  poly_e                 w_loadPoly;
  logic [MAX_N-1:0]      w_seedMasked;
  logic [MAX_N-1:0]      w_genNext;
  logic [DATA_WIDTH-1:0] w_genWord;
  logic [MAX_N-1:0]      w_chkNext;
  logic [DATA_WIDTH-1:0] w_chkWord;
  logic [MAX_N-1:0]      w_chkMask;
  logic [MAX_N-1:0]      w_huntState;
  logic [6:0]            w_fillNext;
  logic                  w_huntFull;
  logic [DATA_WIDTH-1:0] w_mismatch;
  logic [CNT_W:0]        w_popCnt;
  logic [CNT_W:0]        w_errSum;
  logic [CNT_W-1:0]      w_errSat;

  prbs_step #(.DATA_WIDTH(DATA_WIDTH)) u_genStep (
    .i_poly (r_poly),     .i_state(r_genState),
    .o_state(w_genNext),  .o_word (w_genWord)
  );

  prbs_step #(.DATA_WIDTH(DATA_WIDTH)) u_chkStep (
    .i_poly (r_poly),     .i_state(r_chkState),
    .o_state(w_chkNext),  .o_word (w_chkWord)
  );

  assign w_loadPoly   = normPoly(bus.poly_sel_i);
  assign w_seedMasked = bus.seed_i & polyMask(w_loadPoly);

  // Injection rides on the run branch only, so a frozen cycle can never swallow it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_poly     <= DEF_P;
      r_genState <= MAX_N'(1);
      r_genData  <= '0;
      r_genValid <= 1'b0;
    end else if (bus.load_i) begin
      r_poly     <= w_loadPoly;
      r_genState <= (w_seedMasked == '0) ? MAX_N'(1) : w_seedMasked;
      r_genValid <= 1'b0;
    end else if (bus.freeze_i) begin
      r_genValid <= 1'b0;
    end else begin
      r_genData  <= w_genWord ^ DATA_WIDTH'(bus.err_inj_i);
      r_genState <= w_genNext;
      r_genValid <= 1'b1;
    end
  end

  assign w_chkMask  = polyMask(r_poly);
  assign w_fillNext = r_fillCnt + WORD_BITS;
  assign w_huntFull = (w_fillNext >= 7'(TAP_N(r_poly)));
  assign w_mismatch = w_chkWord ^ bus.chk_data_i;

  always_comb begin
    w_huntState = r_chkState;
    for (int k = 0; k < DATA_WIDTH; k++)
      w_huntState = {w_huntState[MAX_N-2:0], bus.chk_data_i[k]} & w_chkMask;
  end

  always_comb begin
    w_popCnt = '0;
    for (int k = 0; k < DATA_WIDTH; k++)
      w_popCnt = w_popCnt + (CNT_W+1)'(w_mismatch[k]);
  end

  assign w_errSum = {1'b0, r_errCnt} + w_popCnt;
  assign w_errSat = w_errSum[CNT_W] ? '1 : w_errSum[CNT_W-1:0];

  // r_beatCnt counts clean beats in VERIFY and consecutive errored beats in LOCKED.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_chkFsm   <= CHK_HUNT;
      r_chkState <= '0;
      r_fillCnt  <= '0;
      r_beatCnt  <= '0;
      r_locked   <= 1'b0;
      r_errCnt   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (bus.load_i) begin
        r_chkFsm  <= CHK_HUNT;
        r_locked  <= 1'b0;
        r_fillCnt <= '0;
        r_beatCnt <= '0;
      end else if (bus.chk_valid_i) begin
        unique case (r_chkFsm)
          CHK_HUNT: begin
            r_chkState <= w_huntState;
            if (w_huntFull) begin
              r_fillCnt <= '0;
              if (w_huntState != '0) begin
                r_chkFsm  <= CHK_VERIFY;
                r_beatCnt <= '0;
              end
            end else begin
              r_fillCnt <= w_fillNext;
            end
          end
          CHK_VERIFY: begin
            r_chkState <= w_chkNext;
            if (w_mismatch != '0) begin
              r_chkFsm  <= CHK_HUNT;
              r_fillCnt <= '0;
            end else if (r_beatCnt == LOCK_LAST) begin
              r_chkFsm  <= CHK_LOCKED;
              r_locked  <= 1'b1;
              r_beatCnt <= '0;
            end else begin
              r_beatCnt <= r_beatCnt + 8'd1;
            end
          end
          CHK_LOCKED: begin
            r_chkState <= w_chkNext;
            r_err      <= (w_mismatch != '0);
            r_errCnt   <= w_errSat;
            if (w_mismatch == '0) begin
              r_beatCnt <= '0;
            end else if (r_beatCnt == LOSS_LAST) begin
              r_chkFsm  <= CHK_HUNT;
              r_locked  <= 1'b0;
              r_fillCnt <= '0;
              r_beatCnt <= '0;
            end else begin
              r_beatCnt <= r_beatCnt + 8'd1;
            end
          end
          default: r_chkFsm <= CHK_HUNT;
        endcase
      end
      if (bus.chk_clear_i) r_errCnt <= '0;
    end
  end

  assign bus.gen_data_o  = r_genData;
  assign bus.gen_valid_o = r_genValid;
  assign bus.locked_o    = r_locked;
  assign bus.err_cnt_o   = r_errCnt;
  assign bus.err_o       = r_err;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: a W=8 instance (4-bit error counter) for generator,
// loopback lock and error counting, and a W=1 instance for serial sequence properties.
module tb_prbs_gen_chk;
  import prbs_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  prbs_gen_chk_if #(.DATA_WIDTH(8), .CNT_W(4))  bus8();
  prbs_gen_chk_if #(.DATA_WIDTH(1), .CNT_W(16)) bus1();

  prbs_gen_chk #(.DATA_WIDTH(8), .CNT_W(4), .DEF_POLY(2), .LOCK_BEATS(4), .LOSS_BEATS(4)) dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus8)
  );

  prbs_gen_chk #(.DATA_WIDTH(1), .CNT_W(16), .DEF_POLY(2), .LOCK_BEATS(4), .LOSS_BEATS(4)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus1)
  );

  logic       loopEn;
  logic [7:0] corruptMask;
  logic [7:0] manualData;
  logic       manualValid;

  assign bus8.chk_data_i  = loopEn ? (bus8.gen_data_o ^ corruptMask) : manualData;
  assign bus8.chk_valid_i = loopEn ? bus8.gen_valid_o : manualValid;
  assign bus1.chk_data_i  = 1'b0;
  assign bus1.chk_valid_i = 1'b0;

  int totalChecks = 0;
  int badChecks   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic load, input logic freeze, input logic inj,
                               input logic [2:0] poly, input logic [30:0] seed);
    bus8.load_i     = load;
    bus8.freeze_i   = freeze;
    bus8.err_inj_i  = inj;
    bus8.poly_sel_i = poly;
    bus8.seed_i     = seed;
  endtask

  logic [6:0]  firstBits;
  logic [6:0]  laterBits;
  logic [27:0] p31Bits;
  int          ones;

  initial begin
    rst_i       = 1'b1;
    loopEn      = 1'b0;
    corruptMask = 8'h00;
    manualData  = 8'h00;
    manualValid = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 31'd0);
    bus8.chk_clear_i = 1'b0;
    bus1.poly_sel_i  = 3'd0;
    bus1.seed_i      = 31'd0;
    bus1.load_i      = 1'b0;
    bus1.freeze_i    = 1'b1;
    bus1.err_inj_i   = 1'b0;
    bus1.chk_clear_i = 1'b0;
    tick(3);
    rst_i = 1'b0;

    checkOutput("rstData",   32'(bus8.gen_data_o),  32'h0);
    checkOutput("rstValid",  32'(bus8.gen_valid_o), 32'h0);
    checkOutput("rstLocked", 32'(bus8.locked_o),    32'h0);
    checkOutput("rstErrCnt", 32'(bus8.err_cnt_o),   32'h0);
    checkOutput("rstErr",    32'(bus8.err_o),       32'h0);
    checkOutput("rstValid1", 32'(bus1.gen_valid_o), 32'h0);

    // Default PRBS15 from state 1: first word empty, second word has bits 5 and 6 set.
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 31'd0);
    tick(1);
    checkOutput("defWord0",  32'(bus8.gen_data_o),  32'h00);
    checkOutput("defValid",  32'(bus8.gen_valid_o), 32'h1);
    tick(1);
    checkOutput("defWord1",  32'(bus8.gen_data_o),  32'h60);

    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 31'h7F);
    tick(1);
    checkOutput("loadFrzValid", 32'(bus8.gen_valid_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 31'h0);
    tick(1);
    checkOutput("p7Word0",  32'(bus8.gen_data_o),  32'h40);
    checkOutput("p7Valid0", 32'(bus8.gen_valid_o), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 31'h0);
    tick(1);
    checkOutput("frzValid", 32'(bus8.gen_valid_o), 32'h0);
    checkOutput("frzHold",  32'(bus8.gen_data_o),  32'h40);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 31'h0);
    tick(1);
    checkOutput("p7Word1",  32'(bus8.gen_data_o),  32'h30);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 31'h0);
    tick(1);
    checkOutput("p7Word2Inj", 32'(bus8.gen_data_o), 32'h15);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 31'h0);
    tick(1);
    checkOutput("p7Word3",  32'(bus8.gen_data_o),  32'h4F);

    // Serial PRBS7: 127-bit period with 64 ones, starting 0000001 from the all-ones seed.
    bus1.poly_sel_i = 3'd0;
    bus1.seed_i     = 31'h7F;
    bus1.load_i     = 1'b1;
    bus1.freeze_i   = 1'b0;
    tick(1);
    bus1.load_i = 1'b0;
    ones = 0;
    firstBits = '0;
    laterBits = '0;
    for (int i = 0; i < 134; i++) begin
      tick(1);
      if (i < 127) ones += int'(bus1.gen_data_o[0]);
      if (i < 7) firstBits[i] = bus1.gen_data_o[0];
      if (i >= 127) laterBits[i-127] = bus1.gen_data_o[0];
    end
    checkOutput("p7Ones",      32'(ones),      32'd64);
    checkOutput("p7FirstBits", 32'(firstBits), 32'h40);
    checkOutput("p7Period",    32'(laterBits), 32'h40);

    for (int pass = 0; pass < 2; pass++) begin
      bus1.poly_sel_i = (pass == 0) ? 3'd4 : 3'd6;
      bus1.seed_i     = 31'd0;
      bus1.load_i     = 1'b1;
      tick(1);
      bus1.load_i = 1'b0;
      p31Bits = '0;
      for (int i = 0; i < 28; i++) begin
        tick(1);
        p31Bits[i] = bus1.gen_data_o[0];
      end
      checkOutput((pass == 0) ? "p31Seed0" : "p31Code6", 32'(p31Bits), 32'h0800_0000);
    end
    bus1.freeze_i = 1'b1;

    // Loopback PRBS15: 2 fill beats then 4 verify beats before lock.
    loopEn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 31'h1234);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd2, 31'h0);
    tick(6);
    checkOutput("preLock",   32'(bus8.locked_o),  32'h0);
    tick(1);
    checkOutput("lockRise",  32'(bus8.locked_o),  32'h1);
    checkOutput("lockErrCnt",32'(bus8.err_cnt_o), 32'h0);

    bus8.err_inj_i = 1'b1;
    tick(1);
    bus8.err_inj_i = 1'b0;
    checkOutput("injErrBefore", 32'(bus8.err_o), 32'h0);
    tick(1);
    checkOutput("injErrPulse",  32'(bus8.err_o),     32'h1);
    checkOutput("injErrCnt",    32'(bus8.err_cnt_o), 32'h1);
    tick(1);
    checkOutput("injErrAfter",  32'(bus8.err_o),    32'h0);
    checkOutput("injLocked",    32'(bus8.locked_o), 32'h1);

    corruptMask = 8'hFF;
    tick(1);
    checkOutput("cnt9",    32'(bus8.err_cnt_o), 32'd9);
    checkOutput("errFF",   32'(bus8.err_o),     32'h1);
    tick(1);
    checkOutput("cntSat",  32'(bus8.err_cnt_o), 32'd15);
    corruptMask = 8'h00;
    tick(1);
    checkOutput("cntSatClean", 32'(bus8.err_cnt_o), 32'd15);
    checkOutput("satLocked",   32'(bus8.locked_o),  32'h1);
    corruptMask = 8'h01;
    tick(1);
    checkOutput("cntSatHold",  32'(bus8.err_cnt_o), 32'd15);
    bus8.chk_clear_i = 1'b1;
    tick(1);
    checkOutput("clearWins",   32'(bus8.err_cnt_o), 32'd0);
    bus8.chk_clear_i = 1'b0;
    corruptMask = 8'h00;
    tick(1);
    checkOutput("clearClean",  32'(bus8.err_cnt_o), 32'd0);

    corruptMask = 8'h01;
    tick(3);
    checkOutput("loss3Locked", 32'(bus8.locked_o),  32'h1);
    checkOutput("loss3Cnt",    32'(bus8.err_cnt_o), 32'd3);
    tick(1);
    checkOutput("loss4Locked", 32'(bus8.locked_o),  32'h0);
    checkOutput("loss4Cnt",    32'(bus8.err_cnt_o), 32'd4);
    checkOutput("loss4Err",    32'(bus8.err_o),     32'h1);
    corruptMask = 8'h00;
    tick(1);
    checkOutput("lossKeptCnt", 32'(bus8.err_cnt_o), 32'd4);
    checkOutput("lossNoErr",   32'(bus8.err_o),     32'h0);

    // Constant-zero input keeps refilling HUNT and must never lock.
    loopEn      = 1'b0;
    manualData  = 8'h00;
    manualValid = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 31'h1234);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd2, 31'h0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checkOutput("zeroNoLock", 32'(bus8.locked_o), 32'h0);
    end
    checkOutput("zeroCntKept", 32'(bus8.err_cnt_o), 32'd4);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
